// File: rtl/icache_fetch_controller_if.sv
// CPU-fetch and instruction-memory signal bundle for the instruction cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface icache_fetch_controller_if;
   logic [31:0] ADDRESS;
   logic        FLUSH;
   logic [31:0] INSTRUCTION;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic [31:0] MEM_ADDRESS;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   modport slave (
      input  ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
      output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

   modport master (
      output ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
      input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );
endinterface

// File: rtl/icache_fetch_controller.sv
// Direct-mapped instruction cache.
// Hits are served combinationally; a miss stalls the CPU and refills the whole line from memory.
module icache_fetch_controller #(
   parameter int LINES = 8,
   parameter int WORDS = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   icache_fetch_controller_if.slave  bus
);
   localparam int IW = $clog2(LINES);
   localparam int OW = $clog2(WORDS);
   localparam int TW = 32 - IW - OW - 2;

   typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [LINES-1:0] r_valid;
   logic [TW-1:0]    r_tag  [LINES];
   logic [31:0]      r_data [LINES][WORDS];
   logic [IW-1:0]    r_idx;
   logic [TW-1:0]    r_tag_lat;
   logic [OW-1:0]    r_cnt;
   logic             r_mem_read;
   logic [31:0]      r_mem_addr;

   logic [OW-1:0]    w_word;
   logic [IW-1:0]    w_index;
   logic [TW-1:0]    w_tag;
   logic [OW-1:0]    w_cnt_inc;
   logic             w_hit;
   logic             w_miss_start;
   logic             w_accept;
   logic             w_last;
   logic             w_busywait;

   assign w_word    = bus.ADDRESS[OW+1:2];
   assign w_index   = bus.ADDRESS[IW+OW+1:OW+2];
   assign w_tag     = bus.ADDRESS[31:IW+OW+2];
   assign w_cnt_inc = r_cnt + OW'(1);
   // Tag array content is only trusted when the valid bit is set.
   assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);

   // Next-state and per-cycle event decode; FLUSH outranks miss detection and word acceptance.
   always_comb begin
      w_next_state = r_state;
      w_miss_start = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      w_busywait   = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busywait = !w_hit;
            if (bus.FLUSH) begin
               w_next_state = S_IDLE;
            end else if (!w_hit) begin
               w_miss_start = 1'b1;
               w_next_state = S_FETCH;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH: begin
            if (bus.FLUSH) begin
               w_next_state = S_IDLE;
            end else if (r_mem_read && !bus.MEM_BUSYWAIT) begin
               w_accept = 1'b1;
               if (r_cnt == OW'(WORDS - 1)) begin
                  w_last       = 1'b1;
                  w_next_state = S_IDLE;
               end else begin
                  w_next_state = S_FETCH;
               end
            end else begin
               w_next_state = S_FETCH;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Valid bits, latched miss line, word counter and registered memory request.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_valid    <= {LINES{1'b0}};
         r_idx      <= {IW{1'b0}};
         r_tag_lat  <= {TW{1'b0}};
         r_cnt      <= {OW{1'b0}};
         r_mem_read <= 1'b0;
         r_mem_addr <= 32'h0000_0000;
      end else if (bus.FLUSH) begin
         r_valid    <= {LINES{1'b0}};
         r_cnt      <= {OW{1'b0}};
         r_mem_read <= 1'b0;
      end else if (w_miss_start) begin
         // Invalidate now so a half-refilled line can never produce a hit.
         r_valid[w_index] <= 1'b0;
         r_idx            <= w_index;
         r_tag_lat        <= w_tag;
         r_cnt            <= {OW{1'b0}};
         r_mem_read       <= 1'b1;
         r_mem_addr       <= {w_tag, w_index, {OW{1'b0}}, 2'b00};
      end else if (w_accept) begin
         if (w_last) begin
            r_valid[r_idx] <= 1'b1;
            r_cnt          <= {OW{1'b0}};
            r_mem_read     <= 1'b0;
         end else begin
            r_cnt      <= w_cnt_inc;
            r_mem_addr <= {r_tag_lat, r_idx, w_cnt_inc, 2'b00};
         end
      end
   end

   // Data and tag storage; not reset, guarded by the valid bits.
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         r_data[r_idx][r_cnt] <= bus.MEM_READDATA;
      end
      if (w_accept && w_last) begin
         r_tag[r_idx] <= r_tag_lat;
      end
   end

   assign bus.INSTRUCTION = r_data[w_index][w_word];
   assign bus.BUSYWAIT    = w_busywait;
   assign bus.MEM_READ    = r_mem_read;
   assign bus.MEM_ADDRESS = r_mem_addr;
endmodule

// File: tb/tb_icache_fetch_controller.sv
// Bench for icache_fetch_controller: hit-vector table, miss/refill sequences and a
// queue of expected memory read addresses consumed as the cache accepts words.
module tb_icache_fetch_controller;
   logic CLK = 1'b0;
   logic RESET;

   icache_fetch_controller_if bus();

   icache_fetch_controller #(.LINES(8), .WORDS(4)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int          n_checks  = 0;
   int          n_errors  = 0;
   int          stall_cfg = 0;
   int          wait_cnt  = 0;
   logic [31:0] exp_q[$];
   logic        prev_read = 1'b0;
   logic        prev_busy = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
   } hit_vec_t;
   hit_vec_t hits[5];

   // Memory model: data = address ^ A5A50000, stall_cfg wait cycles before each word.
   assign bus.MEM_READDATA = bus.MEM_ADDRESS ^ 32'hA5A5_0000;
   assign bus.MEM_BUSYWAIT = bus.MEM_READ && (wait_cnt < stall_cfg);

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) wait_cnt <= 0;
      else if (bus.MEM_READ && (wait_cnt < stall_cfg)) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Read monitor: every word the cache will accept must match the next queued address.
   always @(negedge CLK) begin
      if (RESET === 1'b1 && bus.MEM_READ === 1'b1) begin
         check("read_only_when_stalled", 32'(bus.BUSYWAIT), 32'd1);
         if (prev_read && prev_busy) check("mem_addr_stable", bus.MEM_ADDRESS, prev_addr);
         if (!bus.MEM_BUSYWAIT && !bus.FLUSH) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_read: got %h expected no read", bus.MEM_ADDRESS);
            end else begin
               check("mem_addr_seq", bus.MEM_ADDRESS, exp_q.pop_front());
            end
         end
      end
      prev_read <= bus.MEM_READ;
      prev_busy <= bus.MEM_BUSYWAIT;
      prev_addr <= bus.MEM_ADDRESS;
   end

   task automatic do_miss(input logic [31:0] addr, input int stall, input string name);
      int          cycles = 0;
      logic [31:0] base;
      base      = {addr[31:4], 4'h0};
      stall_cfg = stall;
      for (int w = 0; w < 4; w++) exp_q.push_back(base + 32'(w * 4));
      bus.ADDRESS = addr;
      #1;
      while (bus.BUSYWAIT === 1'b1 && cycles < 200) begin
         cycles++;
         @(posedge CLK);
         #2;
      end
      check({name, "_busy_cycles"}, 32'(cycles), 32'(5 + 4 * stall));
      check({name, "_instr"}, bus.INSTRUCTION, {addr[31:2], 2'b00} ^ 32'hA5A5_0000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      hits[0] = '{32'h0000_0000, 32'hA5A5_0000};
      hits[1] = '{32'h0000_0004, 32'hA5A5_0004};
      hits[2] = '{32'h0000_000C, 32'hA5A5_000C};
      hits[3] = '{32'h0000_0008, 32'hA5A5_0008};
      hits[4] = '{32'h0000_0006, 32'hA5A5_0004};

      RESET       = 1'b0;
      bus.FLUSH   = 1'b0;
      bus.ADDRESS = 32'h0000_0008;
      @(posedge CLK); #1;
      check("rst_busywait", 32'(bus.BUSYWAIT), 32'd1);
      check("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
      check("rst_mem_addr", bus.MEM_ADDRESS, 32'h0);
      @(posedge CLK); #1;
      RESET = 1'b1;
      do_miss(32'h0000_0008, 0, "cold");

      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         bus.ADDRESS = hits[i].addr;
         #1;
         check("hit_busywait", 32'(bus.BUSYWAIT), 32'd0);
         check("hit_instr", bus.INSTRUCTION, hits[i].instr);
         check("hit_mem_read", 32'(bus.MEM_READ), 32'd0);
      end

      @(posedge CLK); #1;
      do_miss(32'h0000_0080, 0, "evict");
      @(posedge CLK); #1;
      do_miss(32'h0000_0000, 0, "remiss");
      @(posedge CLK); #1;
      do_miss(32'h0000_0010, 3, "stall");

      // FLUSH while the third word (counter=2) is being requested.
      @(posedge CLK); #1;
      stall_cfg = 0;
      exp_q.push_back(32'h0000_0020);
      exp_q.push_back(32'h0000_0024);
      bus.ADDRESS = 32'h0000_0020;
      repeat (3) @(posedge CLK);
      #1;
      check("flush_cnt2_addr", bus.MEM_ADDRESS, 32'h0000_0028);
      bus.FLUSH = 1'b1;
      @(posedge CLK); #1;
      bus.FLUSH = 1'b0;
      #1;
      check("flush_mem_read", 32'(bus.MEM_READ), 32'd0);
      check("flush_busywait", 32'(bus.BUSYWAIT), 32'd1);
      do_miss(32'h0000_0020, 0, "flush_refill");
      @(posedge CLK); #1;
      do_miss(32'h0000_0000, 0, "refill0");

      // Asynchronous reset between edges during a refill.
      @(posedge CLK); #1;
      bus.ADDRESS = 32'h0000_0000;
      #1;
      check("pre_reset_hit", 32'(bus.BUSYWAIT), 32'd0);
      bus.ADDRESS = 32'h0000_0040;
      @(posedge CLK); #1;
      check("pre_reset_fetching", 32'(bus.MEM_READ), 32'd1);
      RESET = 1'b0;
      #1;
      check("async_rst_mem_read", 32'(bus.MEM_READ), 32'd0);
      check("async_rst_mem_addr", bus.MEM_ADDRESS, 32'h0);
      check("async_rst_busywait", 32'(bus.BUSYWAIT), 32'd1);
      bus.ADDRESS = 32'h0000_0000;
      @(posedge CLK); #1;
      RESET = 1'b1;
      #1;
      check("post_reset_miss", 32'(bus.BUSYWAIT), 32'd1);
      do_miss(32'h0000_0000, 0, "post_reset");

      @(posedge CLK); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
